// File: rtl/rast_sample_iter.sv
// Walks every subsample of one snapped bounding box in raster order (x fastest) at the
// subsample step, stalling the upstream stage while a box is in flight.
module rast_sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                   validTri_R13H,
    output logic                                   halt_R13L,
    input  logic [3:0]                             subSample_RnnnnU,
    input  logic                                   ready_R14H,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                   validSamp_R14H,
    output logic                                   dbg_state_o
);

    // Handshake: a sample transfers on a cycle with validSamp_R14H=1 and ready_R14H=1;
    // a triangle transfers on a cycle with validTri_R13H=1 and halt_R13L=1.
    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_ITER = 1'b1;

    localparam logic [SIGFIG-1:0] STEP_0 = SIGFIG'(1) << (RADIX - 3);
    localparam logic [SIGFIG-1:0] STEP_1 = SIGFIG'(1) << (RADIX - 2);
    localparam logic [SIGFIG-1:0] STEP_2 = SIGFIG'(1) << (RADIX - 1);
    localparam logic [SIGFIG-1:0] STEP_3 = SIGFIG'(1) << RADIX;

    logic [0:0]                             state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [1:0][1:0][SIGFIG-1:0]            box_q, box_d;
    logic [1:0][SIGFIG-1:0]                 sample_q, sample_d;
    logic [SIGFIG-1:0]                      step_q, step_d;

    logic [SIGFIG-1:0]   step_in;
    logic signed [SIGFIG:0] x_sum, y_sum, ur_x, ur_y;
    logic x_fits, y_fits, last, accept, degen;

    always_comb begin
        step_in = STEP_3;
        if (subSample_RnnnnU[0])      step_in = STEP_0;
        else if (subSample_RnnnnU[1]) step_in = STEP_1;
        else if (subSample_RnnnnU[2]) step_in = STEP_2;
        else if (subSample_RnnnnU[3]) step_in = STEP_3;
    end

    // One extra bit keeps x+step from wrapping past the positive limit.
    always_comb begin
        x_sum  = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
        y_sum  = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
        ur_x   = $signed({box_q[1][0][SIGFIG-1], box_q[1][0]});
        ur_y   = $signed({box_q[1][1][SIGFIG-1], box_q[1][1]});
        x_fits = (x_sum <= ur_x);
        y_fits = (y_sum <= ur_y);
        last   = !x_fits && !y_fits;
        degen  = ($signed(box_R13S[0][0]) > $signed(box_R13S[1][0])) ||
                 ($signed(box_R13S[0][1]) > $signed(box_R13S[1][1]));
    end

    assign halt_R13L      = (state_q == ST_WAIT) || ((state_q == ST_ITER) && last && ready_R14H);
    assign accept         = halt_R13L && validTri_R13H;
    assign validSamp_R14H = (state_q == ST_ITER);
    assign tri_R14S       = tri_q;
    assign sample_R14S    = sample_q;
    assign dbg_state_o    = state_q[0];

    always_comb begin
        state_d  = state_q;
        tri_d    = tri_q;
        box_d    = box_q;
        sample_d = sample_q;
        step_d   = step_q;
        if (accept) begin
            tri_d  = tri_R13S;
            box_d  = box_R13S;
            step_d = step_in;
            if (degen) begin
                state_d = ST_WAIT;
            end else begin
                state_d  = ST_ITER;
                sample_d = box_R13S[0];
            end
        end else if ((state_q == ST_ITER) && ready_R14H) begin
            if (x_fits) begin
                sample_d[0] = x_sum[SIGFIG-1:0];
            end else if (y_fits) begin
                sample_d[0] = box_q[0][0];
                sample_d[1] = y_sum[SIGFIG-1:0];
            end else begin
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_WAIT;
            tri_q    <= '0;
            box_q    <= '0;
            sample_q <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            tri_q    <= tri_d;
            box_q    <= box_d;
            sample_q <= sample_d;
            step_q   <= step_d;
        end
    end

endmodule

// File: tb/tb_rast_sample_iter.sv
// Bench for rast_sample_iter: directed vector table, hand-written multi-cycle sequences and
// random boxes checked against a nested-loop raster model.
module tb_rast_sample_iter;

    localparam int SIGFIG = 24;

    typedef logic [2:0][2:0][SIGFIG-1:0] tri_t;
    typedef struct {
        int         llx, lly, urx, ury;
        logic [3:0] sub;
        int         exp_cnt;
        int         exp_lx, exp_ly;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    tri_t                   tri_R13S = '0;
    logic [1:0][1:0][SIGFIG-1:0] box_R13S = '0;
    logic                   validTri_R13H = 1'b0;
    logic                   halt_R13L;
    logic [3:0]             subSample_RnnnnU = '0;
    logic                   ready_R14H = 1'b0;
    tri_t                   tri_R14S;
    logic [1:0][SIGFIG-1:0] sample_R14S;
    logic                   validSamp_R14H;
    logic                   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*SIGFIG-1:0] exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    rast_sample_iter dut (
        .clk(clk), .rst(rst), .tri_R13S(tri_R13S), .box_R13S(box_R13S),
        .validTri_R13H(validTri_R13H), .halt_R13L(halt_R13L),
        .subSample_RnnnnU(subSample_RnnnnU), .ready_R14H(ready_R14H),
        .tri_R14S(tri_R14S), .sample_R14S(sample_R14S),
        .validSamp_R14H(validSamp_R14H), .dbg_state_o(dbg_state)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int step_of(input logic [3:0] sub);
        if (sub[0]) return 128;
        if (sub[1]) return 256;
        if (sub[2]) return 512;
        return 1024;
    endfunction

    // Reference: every grid point LL + k*step inside the box, rows bottom-up, x fastest.
    task automatic model_box(input int llx, lly, urx, ury, input int step);
        logic [SIGFIG-1:0] xs, ys;
        exp_q.delete();
        if (llx > urx || lly > ury) return;
        for (int y = lly; y <= ury; y += step) begin
            for (int x = llx; x <= urx; x += step) begin
                xs = x[SIGFIG-1:0];
                ys = y[SIGFIG-1:0];
                exp_q.push_back({ys, xs});
            end
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive_box(input int llx, lly, urx, ury, input logic [3:0] sub, input tri_t t);
        box_R13S[0][0]   = llx[SIGFIG-1:0];
        box_R13S[0][1]   = lly[SIGFIG-1:0];
        box_R13S[1][0]   = urx[SIGFIG-1:0];
        box_R13S[1][1]   = ury[SIGFIG-1:0];
        tri_R13S         = t;
        subSample_RnnnnU = sub;
    endtask

    function automatic tri_t rand_tri();
        tri_t t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                t[i][j] = SIGFIG'($urandom());
        return t;
    endfunction

    task automatic run_box(input int llx, lly, urx, ury, input logic [3:0] sub, input int mode,
                           output int cnt, output int lx, output int ly, output int halt_low);
        tri_t t;
        logic [2*SIGFIG-1:0] prev, e;
        logic prev_v, prev_r;
        int k, g;
        t = rand_tri();
        model_box(llx, lly, urx, ury, step_of(sub));
        cnt = 0; lx = 0; ly = 0; halt_low = 0; k = 0; prev_v = 0; prev_r = 1; prev = '0;
        drive_box(llx, lly, urx, ury, sub, t);
        validTri_R13H = 1'b1;
        ready_R14H    = rdy(mode, k);
        for (g = 0; g < 100 && !halt_R13L; g++) @(negedge clk);
        if (g == 100) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        validTri_R13H    = 1'b0;
        subSample_RnnnnU = 4'($urandom());
        box_R13S         = '0;
        tri_R13S         = rand_tri();
        for (g = 0; g < 20000; g++) begin
            @(negedge clk);
            if (!validSamp_R14H) break;
            if (prev_v && !prev_r) chk("hold", sample_R14S, prev);
            if (ready_R14H) begin
                cnt++;
                if (!halt_R13L) halt_low++;
                if (exp_q.size() == 0) begin
                    chk("extra_sample", sample_R14S, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample", sample_R14S, e);
                end
                chk("tri", tri_R14S, t);
                lx = int'($signed(sample_R14S[0]));
                ly = int'($signed(sample_R14S[1]));
            end
            prev_v = 1'b1;
            prev_r = ready_R14H;
            prev   = sample_R14S;
            @(posedge clk);
            #1;
            k++;
            ready_R14H = rdy(mode, k);
        end
        if (g == 20000) chk("iter_timeout", 1, 0);
        chk("missing_samples", exp_q.size(), 0);
    endtask

    initial begin
        int cnt, lx, ly, hl, seen, vcnt;
        int llx, lly, w, h;
        logic [3:0] sub;

        vecs[0] = '{0, 0, 2048, 1024, 4'b1000, 6, 2048, 1024};
        vecs[1] = '{0, 0, 2048, 1024, 4'b0100, 15, 2048, 1024};
        vecs[2] = '{0, 0, 2048, 1024, 4'b0000, 6, 2048, 1024};
        vecs[3] = '{0, 0, 2048, 1024, 4'b0011, 153, 2048, 1024};
        vecs[4] = '{512, 512, 512, 512, 4'b1000, 1, 512, 512};
        vecs[5] = '{-1024, -512, 0, 0, 4'b0110, 15, 0, 0};
        vecs[6] = '{8386432, 0, 8388480, 0, 4'b1000, 3, 8388480, 0};
        vecs[7] = '{0, 0, 1000, 0, 4'b0100, 2, 512, 0};

        // Reset state
        #3;
        chk("rst_valid", validSamp_R14H, 0);
        chk("rst_sample", sample_R14S, 0);
        chk("rst_tri", tri_R14S, 0);
        chk("rst_halt", halt_R13L, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_box(vecs[i].llx, vecs[i].lly, vecs[i].urx, vecs[i].ury, vecs[i].sub, 0,
                    cnt, lx, ly, hl);
            chk($sformatf("vec%0d_count", i), cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_last_x", i), lx, vecs[i].exp_lx);
            chk($sformatf("vec%0d_last_y", i), ly, vecs[i].exp_ly);
            chk($sformatf("vec%0d_halt_low", i), hl, vecs[i].exp_cnt - 1);
        end

        // ready toggling 1,0,0,1
        run_box(0, 0, 2048, 1024, 4'b1000, 1, cnt, lx, ly, hl);
        chk("toggle_count", cnt, 6);
        chk("toggle_last_x", lx, 2048);

        // Back-to-back: single-sample box then a 2-sample row, no bubble
        drive_box(512, 512, 512, 512, 4'b1000, rand_tri());
        validTri_R13H = 1'b1;
        ready_R14H    = 1'b1;
        @(posedge clk);
        #1;
        drive_box(0, 0, 1024, 0, 4'b1000, rand_tri());
        @(negedge clk);
        chk("b2b_v0", validSamp_R14H, 1);
        chk("b2b_s0", sample_R14S, {24'd512, 24'd512});
        chk("b2b_halt0", halt_R13L, 1);
        @(posedge clk);
        #1;
        validTri_R13H = 1'b0;
        @(negedge clk);
        chk("b2b_v1", validSamp_R14H, 1);
        chk("b2b_s1", sample_R14S, {24'd0, 24'd0});
        @(negedge clk);
        chk("b2b_v2", validSamp_R14H, 1);
        chk("b2b_s2", sample_R14S, {24'd0, 24'd1024});
        chk("b2b_halt2", halt_R13L, 1);
        @(negedge clk);
        chk("b2b_end", validSamp_R14H, 0);

        // Degenerate box: accepted and dropped
        run_box(2048, 0, 1024, 0, 4'b1000, 0, cnt, lx, ly, hl);
        chk("degen_count", cnt, 0);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (validSamp_R14H || !halt_R13L) vcnt++;
        end
        chk("degen_idle", vcnt, 0);

        // Reset after the third sample
        drive_box(0, 0, 2048, 1024, 4'b1000, rand_tri());
        validTri_R13H = 1'b1;
        ready_R14H    = 1'b1;
        @(posedge clk);
        #1;
        validTri_R13H = 1'b0;
        seen = 0;
        for (int g = 0; g < 50 && seen < 3; g++) begin
            @(negedge clk);
            if (validSamp_R14H) seen++;
        end
        chk("rst_mid_seen", seen, 3);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", validSamp_R14H, 0);
        chk("rst_mid_sample", sample_R14S, 0);
        chk("rst_mid_halt", halt_R13L, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (validSamp_R14H) vcnt++;
        end
        chk("rst_mid_quiet", vcnt, 0);

        // Random boxes with random ready
        for (int r = 0; r < 25; r++) begin
            llx = 128 * $urandom_range(0, 64) - 4096;
            lly = 128 * $urandom_range(0, 64) - 4096;
            w   = 128 * $urandom_range(0, 16);
            h   = 128 * $urandom_range(0, 16);
            sub = 4'($urandom());
            if ($urandom_range(0, 7) == 0)
                run_box(llx, lly, llx - 128 - w, lly + h, sub, 2, cnt, lx, ly, hl);
            else
                run_box(llx, lly, llx + w, lly + h, sub, 2, cnt, lx, ly, hl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
